// File: rtl/systolic_drain_4_pkg.sv
// systolic_drain_4_pkg
// Constants shared by the systolic array drain block and its column FIFOs.
//   NUM_COLS  : number of array columns feeding the drain (4)
//   ROW_CNT_W : width of the handed-off row counter (8, wraps 255 -> 0)
package systolic_drain_4_pkg;

  localparam int NUM_COLS  = 4;
  localparam int ROW_CNT_W = 8;

  // A row is complete only when every column has a word waiting.
  function automatic logic all_cols_ready(input logic [NUM_COLS-1:0] non_empty);
    return &non_empty;
  endfunction

endpackage

// File: rtl/drain_col_fifo.sv
// drain_col_fifo
// Synchronous FIFO of FIFO_DEPTH x DATA_WIDTH buffering one array column.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (storage reset to 0)
//   clr        : synchronous flush, wins over push and pop
//   push       : write data_in this cycle (accepted if not full after pop)
//   data_in    : word to write
//   pop        : remove the head this cycle (ignored when empty)
//   head       : current head word (registered storage, no input path)
//   empty/full : occupancy flags
//   drop       : one-cycle pulse, a push was rejected because full
module drain_col_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full,
  output logic                  drop
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           count;
  logic                  do_pop;
  logic                  do_push;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/systolic_drain_4.sv
// systolic_drain_4
// Receiving end of the 4x4 systolic array's down edge. Each column's skewed
// results are buffered in a private FIFO; once all four hold a word, one
// aligned row is offered on a valid/ready handshake.
// Ports:
//   drain_clk, drain_rst_n      : clock, asynchronous active-low reset
//   drain_clr                   : synchronous flush of FIFOs, overflow, row count
//   drain_en_in_j/data_in_j     : column j result strobe and word
//   drain_out_valid/ready/data  : aligned row handshake, column 0 in the LSBs
//   drain_overflow              : sticky, a column push was dropped
//   drain_row_cnt               : rows handed off, wraps
//   drain_busy                  : some column FIFO is non-empty
module systolic_drain_4
  import systolic_drain_4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             drain_clk,
  input  logic                             drain_rst_n,
  input  logic                             drain_clr,
  input  logic                             drain_en_in_0,
  input  logic                             drain_en_in_1,
  input  logic                             drain_en_in_2,
  input  logic                             drain_en_in_3,
  input  logic [DATA_WIDTH-1:0]            drain_data_in_0,
  input  logic [DATA_WIDTH-1:0]            drain_data_in_1,
  input  logic [DATA_WIDTH-1:0]            drain_data_in_2,
  input  logic [DATA_WIDTH-1:0]            drain_data_in_3,
  output logic                             drain_out_valid,
  input  logic                             drain_out_ready,
  output logic [NUM_COLS*DATA_WIDTH-1:0]   drain_out_data,
  output logic                             drain_overflow,
  output logic [ROW_CNT_W-1:0]             drain_row_cnt,
  output logic                             drain_busy
);

  logic [NUM_COLS-1:0]   en_col;
  logic [NUM_COLS-1:0]   empty_col;
  logic [NUM_COLS-1:0]   full_col;
  logic [NUM_COLS-1:0]   drop_col;
  logic [DATA_WIDTH-1:0] data_col [NUM_COLS];
  logic [DATA_WIDTH-1:0] head_col [NUM_COLS];
  logic                  pop;
  logic                  ovf_set;

  assign en_col      = {drain_en_in_3, drain_en_in_2, drain_en_in_1, drain_en_in_0};
  assign data_col[0] = drain_data_in_0;
  assign data_col[1] = drain_data_in_1;
  assign data_col[2] = drain_data_in_2;
  assign data_col[3] = drain_data_in_3;

  // Valid depends only on registered occupancy, so it is held until the pop.
  assign drain_out_valid = all_cols_ready(~empty_col);
  assign drain_busy      = |(~empty_col);
  assign pop             = drain_out_valid & drain_out_ready;

  // A drop can only come from a full column.
  assign ovf_set = |(drop_col & full_col);

  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
    drain_col_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (drain_clk),
      .rst_n   (drain_rst_n),
      .clr     (drain_clr),
      .push    (en_col[gi]),
      .data_in (data_col[gi]),
      .pop     (pop),
      .head    (head_col[gi]),
      .empty   (empty_col[gi]),
      .full    (full_col[gi]),
      .drop    (drop_col[gi])
    );

    assign drain_out_data[gi*DATA_WIDTH +: DATA_WIDTH] = head_col[gi];
  end

  always_ff @(posedge drain_clk or negedge drain_rst_n) begin
    if (!drain_rst_n) begin
      drain_row_cnt  <= '0;
      drain_overflow <= 1'b0;
    end else if (drain_clr) begin
      drain_row_cnt  <= '0;
      drain_overflow <= 1'b0;
    end else begin
      if (pop) begin
        drain_row_cnt <= drain_row_cnt + 1'b1;
      end
      if (ovf_set) begin
        drain_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_drain_4.sv
module tb_systolic_drain_4;

  localparam int DW = 32;

  logic           drain_clk = 1'b0;
  logic           drain_rst_n;
  logic           drain_clr;
  logic           drain_en_in_0, drain_en_in_1, drain_en_in_2, drain_en_in_3;
  logic [DW-1:0]  drain_data_in_0, drain_data_in_1, drain_data_in_2, drain_data_in_3;
  logic           drain_out_valid;
  logic           drain_out_ready;
  logic [4*DW-1:0] drain_out_data;
  logic           drain_overflow;
  logic [7:0]     drain_row_cnt;
  logic           drain_busy;

  systolic_drain_4 #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .drain_clk       (drain_clk),
    .drain_rst_n     (drain_rst_n),
    .drain_clr       (drain_clr),
    .drain_en_in_0   (drain_en_in_0),
    .drain_en_in_1   (drain_en_in_1),
    .drain_en_in_2   (drain_en_in_2),
    .drain_en_in_3   (drain_en_in_3),
    .drain_data_in_0 (drain_data_in_0),
    .drain_data_in_1 (drain_data_in_1),
    .drain_data_in_2 (drain_data_in_2),
    .drain_data_in_3 (drain_data_in_3),
    .drain_out_valid (drain_out_valid),
    .drain_out_ready (drain_out_ready),
    .drain_out_data  (drain_out_data),
    .drain_overflow  (drain_overflow),
    .drain_row_cnt   (drain_row_cnt),
    .drain_busy      (drain_busy)
  );

  always #5 drain_clk = ~drain_clk;

  typedef struct packed {
    logic [3:0]   en;
    logic [127:0] din;
    logic         ready;
    logic         clr;
    logic         exp_valid;
    logic         chk_data;
    logic [127:0] exp_data;
    logic         exp_ovf;
    logic [7:0]   exp_cnt;
    logic         exp_busy;
  } vec_t;

  vec_t tbl[$];
  int   split_idx;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [127:0] row4(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [127:0] rr(input logic [31:0] base);
    return row4(base, base + 32'd1, base + 32'd2, base + 32'd3);
  endfunction

  function automatic vec_t mk(input logic [3:0] en, input logic [127:0] din,
                              input logic ready, input logic clr,
                              input logic ev, input logic cd, input logic [127:0] ed,
                              input logic eo, input logic [7:0] ec, input logic eb);
    vec_t v;
    v.en = en; v.din = din; v.ready = ready; v.clr = clr;
    v.exp_valid = ev; v.chk_data = cd; v.exp_data = ed;
    v.exp_ovf = eo; v.exp_cnt = ec; v.exp_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [127:0] din,
                       input logic rdy, input logic clr);
    drain_en_in_0   = en[0];
    drain_en_in_1   = en[1];
    drain_en_in_2   = en[2];
    drain_en_in_3   = en[3];
    drain_data_in_0 = din[31:0];
    drain_data_in_1 = din[63:32];
    drain_data_in_2 = din[95:64];
    drain_data_in_3 = din[127:96];
    drain_out_ready = rdy;
    drain_clr       = clr;
  endtask

  task automatic step();
    @(posedge drain_clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    drive(v.en, v.din, v.ready, v.clr);
    step();
    chk($sformatf("v%0d valid", i), drain_out_valid, v.exp_valid);
    if (v.chk_data) chk($sformatf("v%0d data", i), drain_out_data, v.exp_data);
    chk($sformatf("v%0d overflow", i), drain_overflow, v.exp_ovf);
    chk($sformatf("v%0d row_cnt", i), drain_row_cnt, v.exp_cnt);
    chk($sformatf("v%0d busy", i), drain_busy, v.exp_busy);
  endtask

  initial begin
    // Aligned row, then a skewed row.
    tbl.push_back(mk(4'b1111, row4(32'h11, 32'h22, 32'h33, 32'h44), 1, 0,
                     1, 1, row4(32'h11, 32'h22, 32'h33, 32'h44), 0, 8'd0, 1));
    tbl.push_back(mk(4'b0000, '0, 1, 0, 0, 0, '0, 0, 8'd1, 0));
    tbl.push_back(mk(4'b0001, row4(32'hA0, 0, 0, 0), 1, 0, 0, 0, '0, 0, 8'd1, 1));
    tbl.push_back(mk(4'b0010, row4(0, 32'hA1, 0, 0), 1, 0, 0, 0, '0, 0, 8'd1, 1));
    tbl.push_back(mk(4'b0100, row4(0, 0, 32'hA2, 0), 1, 0, 0, 0, '0, 0, 8'd1, 1));
    tbl.push_back(mk(4'b1000, row4(0, 0, 0, 32'hA3), 1, 0,
                     1, 1, row4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 0, 8'd1, 1));
    tbl.push_back(mk(4'b0000, '0, 1, 0, 0, 0, '0, 0, 8'd2, 0));
    split_idx = tbl.size();
    // Backpressure: fill four rows, drop a fifth word, then drain.
    for (int r = 0; r < 4; r++)
      tbl.push_back(mk(4'b1111, rr(32'hC000 + 32'(r * 16)), 0, 0,
                       1, 1, rr(32'hC000), 0, 8'd8, 1));
    tbl.push_back(mk(4'b0001, row4(32'hDEAD, 0, 0, 0), 0, 0, 1, 1, rr(32'hC000), 1, 8'd8, 1));
    tbl.push_back(mk(4'b0000, '0, 1, 0, 1, 1, rr(32'hC010), 1, 8'd9, 1));
    tbl.push_back(mk(4'b0000, '0, 1, 0, 1, 1, rr(32'hC020), 1, 8'd10, 1));
    tbl.push_back(mk(4'b0000, '0, 1, 0, 1, 1, rr(32'hC030), 1, 8'd11, 1));
    tbl.push_back(mk(4'b0000, '0, 1, 0, 0, 0, '0, 1, 8'd12, 0));
    // Clear with a word pending and overflow set; same-cycle pushes discarded.
    tbl.push_back(mk(4'b0001, row4(32'h1, 0, 0, 0), 0, 0, 0, 0, '0, 1, 8'd12, 1));
    tbl.push_back(mk(4'b1111, row4(32'h77, 32'h77, 32'h77, 32'h77), 1, 1, 0, 0, '0, 0, 8'd0, 0));
    tbl.push_back(mk(4'b0000, '0, 0, 0, 0, 0, '0, 0, 8'd0, 0));
    // Full FIFOs with simultaneous push and pop.
    for (int r = 0; r < 4; r++)
      tbl.push_back(mk(4'b1111, rr(32'hE000 + 32'(r * 16)), 0, 0,
                       1, 1, rr(32'hE000), 0, 8'd0, 1));
    tbl.push_back(mk(4'b1111, row4(32'h55, 32'h55, 32'h55, 32'h55), 1, 0,
                     1, 1, rr(32'hE010), 0, 8'd1, 1));
    tbl.push_back(mk(4'b0000, '0, 1, 0, 1, 1, rr(32'hE020), 0, 8'd2, 1));
    tbl.push_back(mk(4'b0000, '0, 1, 0, 1, 1, rr(32'hE030), 0, 8'd3, 1));
    tbl.push_back(mk(4'b0000, '0, 1, 0, 1, 1, row4(32'h55, 32'h55, 32'h55, 32'h55), 0, 8'd4, 1));
    tbl.push_back(mk(4'b0000, '0, 1, 0, 0, 0, '0, 0, 8'd5, 0));
    // One-entry FIFOs with simultaneous push and pop.
    tbl.push_back(mk(4'b1111, row4(32'h66, 32'h66, 32'h66, 32'h66), 0, 0,
                     1, 1, row4(32'h66, 32'h66, 32'h66, 32'h66), 0, 8'd5, 1));
    tbl.push_back(mk(4'b1111, row4(32'h77, 32'h77, 32'h77, 32'h77), 1, 0,
                     1, 1, row4(32'h77, 32'h77, 32'h77, 32'h77), 0, 8'd6, 1));
    tbl.push_back(mk(4'b0000, '0, 1, 0, 0, 0, '0, 0, 8'd7, 0));

    // Reset state.
    drain_rst_n = 1'b0;
    drive(4'b0000, '0, 1'b0, 1'b0);
    #2;
    chk("reset valid", drain_out_valid, 0);
    chk("reset data", drain_out_data, 0);
    chk("reset overflow", drain_overflow, 0);
    chk("reset row_cnt", drain_row_cnt, 0);
    chk("reset busy", drain_busy, 0);
    #10 drain_rst_n = 1'b1;

    for (int i = 0; i < split_idx; i++) run_vec(i);

    // Diagonal: column j pushes row r at cycle r+j.
    begin
      int k;
      logic [3:0]   en;
      logic [127:0] din;
      drive(4'b0000, '0, 1'b0, 1'b1);
      step();
      k = 0;
      for (int t = 0; t < 16; t++) begin
        en  = '0;
        din = '0;
        for (int j = 0; j < 4; j++) begin
          if (t - j >= 0 && t - j < 8) begin
            en[j] = 1'b1;
            din[j*32 +: 32] = 32'hD000 + 32'((t - j) * 16 + j);
          end
        end
        drive(en, din, 1'b1, 1'b0);
        step();
        if (drain_out_valid) begin
          if (k < 8) chk($sformatf("diag row%0d", k), drain_out_data, rr(32'hD000 + 32'(k * 16)));
          else chk("diag extra row", 1, 0);
          k++;
        end
      end
      chk("diag rows seen", 128'(k), 128'd8);
      chk("diag row_cnt", drain_row_cnt, 8);
      chk("diag busy", drain_busy, 0);
    end

    for (int i = split_idx; i < tbl.size(); i++) run_vec(i);

    // Stream 256 rows back to back; counter wraps.
    drive(4'b0000, '0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 256; i++) begin
      drive(4'b1111, row4(32'(i), 32'(i), 32'(i), 32'(i)), 1'b1, 1'b0);
      step();
      chk($sformatf("stream row%0d", i), drain_out_data, row4(32'(i), 32'(i), 32'(i), 32'(i)));
    end
    chk("stream row_cnt 255", drain_row_cnt, 255);
    drive(4'b0000, '0, 1'b1, 1'b0);
    step();
    chk("wrap row_cnt", drain_row_cnt, 0);
    chk("wrap valid", drain_out_valid, 0);

    // Asynchronous reset while a row is valid.
    drive(4'b1111, row4(32'h88, 32'h88, 32'h88, 32'h88), 1'b0, 1'b0);
    step();
    drive(4'b1111, row4(32'h89, 32'h89, 32'h89, 32'h89), 1'b1, 1'b0);
    step();
    chk("pre-reset valid", drain_out_valid, 1);
    chk("pre-reset row_cnt", drain_row_cnt, 1);
    drive(4'b0000, '0, 1'b0, 1'b0);
    #3 drain_rst_n = 1'b0;
    #1;
    chk("midreset valid", drain_out_valid, 0);
    chk("midreset data", drain_out_data, 0);
    chk("midreset row_cnt", drain_row_cnt, 0);
    chk("midreset busy", drain_busy, 0);
    #2 drain_rst_n = 1'b1;
    drive(4'b1111, row4(32'h91, 32'h92, 32'h93, 32'h94), 1'b0, 1'b0);
    step();
    chk("post-reset valid", drain_out_valid, 1);
    chk("post-reset data", drain_out_data, row4(32'h91, 32'h92, 32'h93, 32'h94));
    chk("post-reset row_cnt", drain_row_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
